can_stuff_seq: RTL and testbench

Bit-level stuffing sequencer for the CAN controller. It sits between the frame builder/decoder and the bus bit-timing logic, and has two independent paths. The transmit path pulls frame bits over a ready/valid handshake, one per bit time, and inserts complementary stuff bits across the stuffed region (SOF through CRC). The receive path removes stuff bits, checks them, and forwards data bits to the frame decoder.

---
 rtl/can_stuff_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_can_stuff_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_stuff_seq.sv
// CAN bit stuffing sequencer: TX inserts complementary stuff bits from SOF through CRC,
// RX removes and checks them, then both paths run unstuffed until end of frame.
module can_stuff_seq #(
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic bit_tick,
  input  logic src_bit,
  input  logic src_valid,
  input  logic src_stuff_end,
  input  logic src_last,
  output logic src_ready,
  output logic tx_bit,
  output logic tx_stuff,
  output logic tx_busy,
  output logic tx_underrun,
  input  logic tx_start,
  input  logic rx_bit,
  input  logic rx_start,
  input  logic rx_stuff_end,
  input  logic rx_stop,
  output logic rx_data,
  output logic rx_data_valid,
  output logic stuff_error
);

  localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [1:0] {T_IDLE, T_STUFF, T_PLAIN} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_STUFF, R_PLAIN} rx_state_e;

  // Saturating run-length update shared by both paths.
  function automatic logic [RUN_W-1:0] run_step(input logic [RUN_W-1:0] run,
                                                input logic last, input logic b);
    if (b != last)         return RUN_ONE;
    else if (run == RUN_MAX) return RUN_MAX;
    else                   return run + RUN_ONE;
  endfunction

  // ---------------- transmit path ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [RUN_W-1:0] tx_run_q, tx_run_d, tx_run_cur, tx_run_new;
  logic             tx_last_q, tx_last_d;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_stuff_q, tx_stuff_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             tx_tail_q, tx_tail_d;   // stuff bit owed after the final CRC bit
  logic             tx_done_q, tx_done_d;   // last frame bit is on the bus
  logic             tx_active, tx_stuff_due;

  // A start tick behaves as T_STUFF with an empty run.
  assign tx_run_cur   = (tx_state_q == T_IDLE) ? '0 : tx_run_q;
  assign tx_run_new   = run_step(tx_run_cur, tx_last_q, src_bit);
  assign tx_active    = (tx_state_q == T_IDLE) ? tx_start : !tx_done_q;
  assign tx_stuff_due = (tx_state_q == T_STUFF) && (tx_run_q == RUN_MAX);
  assign src_ready    = bit_tick && tx_active && !tx_stuff_due;

  // NOTE: every next-state signal gets a default before any branch, so no latches are inferred.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_run_d      = tx_run_q;
    tx_last_d     = tx_last_q;
    tx_bit_d      = tx_bit_q;
    tx_stuff_d    = tx_stuff_q;
    tx_tail_d     = tx_tail_q;
    tx_done_d     = tx_done_q;
    tx_underrun_d = 1'b0;
    if (bit_tick) begin
      tx_stuff_d = 1'b0;
      if (tx_state_q == T_IDLE && !tx_start) begin
        tx_bit_d = 1'b1;
      end else if (tx_done_q) begin
        tx_state_d = T_IDLE;
        tx_bit_d   = 1'b1;
        tx_done_d  = 1'b0;
      end else if (tx_stuff_due) begin
        tx_bit_d   = ~tx_last_q;
        tx_stuff_d = 1'b1;
        tx_run_d   = RUN_ONE;
        tx_last_d  = ~tx_last_q;
        if (tx_tail_q) begin
          tx_state_d = T_PLAIN;
          tx_tail_d  = 1'b0;
        end
      end else if (!src_valid) begin
        tx_underrun_d = 1'b1;
        tx_state_d    = T_IDLE;
        tx_bit_d      = 1'b1;
        tx_tail_d     = 1'b0;
      end else begin
        tx_bit_d  = src_bit;
        tx_last_d = src_bit;
        tx_run_d  = tx_run_new;
        if (tx_state_q == T_PLAIN) begin
          tx_done_d = src_last;
        end else begin
          tx_state_d = T_STUFF;
          if (src_stuff_end) begin
            if (tx_run_new == RUN_MAX) tx_tail_d  = 1'b1;
            else                       tx_state_d = T_PLAIN;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q    <= T_IDLE;
      tx_run_q      <= '0;
      tx_last_q     <= 1'b1;
      tx_bit_q      <= 1'b1;
      tx_stuff_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      tx_tail_q     <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_run_q      <= tx_run_d;
      tx_last_q     <= tx_last_d;
      tx_bit_q      <= tx_bit_d;
      tx_stuff_q    <= tx_stuff_d;
      tx_underrun_q <= tx_underrun_d;
      tx_tail_q     <= tx_tail_d;
      tx_done_q     <= tx_done_d;
    end
  end

  assign tx_bit      = tx_bit_q;
  assign tx_stuff    = tx_stuff_q;
  assign tx_busy     = (tx_state_q != T_IDLE);
  assign tx_underrun = tx_underrun_q;

  // ---------------- receive path ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [RUN_W-1:0] rx_run_q, rx_run_d;
  logic             rx_last_q, rx_last_d;
  logic             rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic             rx_stuff_due;

  assign rx_stuff_due = (rx_state_q == R_STUFF) && (rx_run_q == RUN_MAX);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_run_d   = rx_run_q;
    rx_last_d  = rx_last_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (rx_start) begin
      rx_state_d = R_STUFF;
      rx_run_d   = '0;
      rx_last_d  = 1'b1;
    end else if (rx_stop) begin
      rx_state_d = R_IDLE;
    end else begin
      case (rx_state_q)
        R_STUFF: begin
          if (rx_stuff_due) begin
            // A pending stuff bit is checked even once the stuffed region has ended.
            if (bit_tick) begin
              if (rx_bit == rx_last_q) begin
                rx_err_d   = 1'b1;
                rx_state_d = R_IDLE;
              end else begin
                rx_run_d  = RUN_ONE;
                rx_last_d = rx_bit;
                if (rx_stuff_end) rx_state_d = R_PLAIN;
              end
            end
          end else begin
            if (bit_tick) begin
              rx_data_d  = rx_bit;
              rx_valid_d = 1'b1;
              rx_run_d   = run_step(rx_run_q, rx_last_q, rx_bit);
              rx_last_d  = rx_bit;
            end
            if (rx_stuff_end) rx_state_d = R_PLAIN;
          end
        end
        R_PLAIN: begin
          if (bit_tick) begin
            rx_data_d  = rx_bit;
            rx_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_run_q   <= '0;
      rx_last_q  <= 1'b1;
      rx_data_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_run_q   <= rx_run_d;
      rx_last_q  <= rx_last_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = rx_valid_q;
  assign stuff_error   = rx_err_q;

endmodule

// File: tb/tb_can_stuff_seq.sv
// Randomized scoreboard bench for can_stuff_seq: a frame-level stuffing model predicts
// every TX bus bit and RX delivery; a negedge monitor compares as the DUT produces them.
module tb_can_stuff_seq;
  localparam int L = 5;

  logic clock = 1'b0, reset = 1'b1;
  logic bit_tick = 1'b0, src_bit = 1'b0, src_valid = 1'b0, src_stuff_end = 1'b0, src_last = 1'b0;
  logic tx_start = 1'b0, rx_bit = 1'b1, rx_start = 1'b0, rx_stuff_end = 1'b0, rx_stop = 1'b0;
  logic src_ready, tx_bit, tx_stuff, tx_busy, tx_underrun, rx_data, rx_data_valid, stuff_error;

  always #5 clock = ~clock;

  can_stuff_seq #(.STUFF_LEN(L)) dut (
    .clock(clock), .reset(reset), .bit_tick(bit_tick),
    .src_bit(src_bit), .src_valid(src_valid), .src_stuff_end(src_stuff_end), .src_last(src_last),
    .src_ready(src_ready), .tx_bit(tx_bit), .tx_stuff(tx_stuff), .tx_busy(tx_busy),
    .tx_underrun(tx_underrun), .tx_start(tx_start),
    .rx_bit(rx_bit), .rx_start(rx_start), .rx_stuff_end(rx_stuff_end), .rx_stop(rx_stop),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .stuff_error(stuff_error)
  );

  typedef struct packed {logic ready; logic b; logic stuff; logic und; logic busy;} tx_exp_t;
  typedef struct packed {logic err; logic b;} rx_exp_t;
  typedef struct {logic b; logic stuff; int idx;} elt_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];
  logic    frame_bits[$];
  logic    rx_bits[$];
  elt_t    stream_q[$];
  int      n_vec = 0, n_miss = 0;
  logic    rx_se_done = 1'b0;
  logic    tx_have = 1'b0;

  function automatic tx_exp_t mk_tx(input logic r, b, s, u, bz);
    tx_exp_t e;
    e.ready = r; e.b = b; e.stuff = s; e.und = u; e.busy = bz;
    return e;
  endfunction

  function automatic rx_exp_t mk_rx(input logic err, b);
    rx_exp_t e;
    e.err = err; e.b = b;
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stuffed bus stream of frame_bits: after L equal bus bits inside the stuffed
  // region (indices 0..se) a complementary bit is inserted.
  function automatic void build_stream(input int se);
    int   run;
    logic prev;
    elt_t e;
    run = 0; prev = 1'b1;
    stream_q.delete();
    for (int j = 0; j < frame_bits.size(); j++) begin
      e.b = frame_bits[j]; e.stuff = 1'b0; e.idx = j;
      stream_q.push_back(e);
      if (j <= se) begin
        run  = (run > 0 && e.b == prev) ? run + 1 : 1;
        prev = e.b;
        if (run == L) begin
          e.b = ~prev; e.stuff = 1'b1; e.idx = -1;
          stream_q.push_back(e);
          prev = ~prev;
          run  = 1;
        end
      end
    end
  endfunction

  function automatic void rand_frame(input int n);
    logic b;
    b = 1'($urandom_range(0, 1));
    frame_bits.delete();
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      frame_bits.push_back(b);
    end
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
    bit_tick = 1'b0; tx_start = 1'b0; src_valid = 1'b0; src_stuff_end = 1'b0; src_last = 1'b0;
    src_bit = 1'($urandom_range(0, 1));
    rx_start = 1'b0; rx_stop = 1'b0; rx_stuff_end = rx_se_done;
  endtask

  task automatic gap();
    int g;
    g = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
    repeat (g) next_cycle();
  endtask

  // Sends frame_bits; und_at drops src_valid on that frame bit, stop_after cuts the stream short.
  task automatic tx_frame(input int se, input int und_at, input int stop_after);
    int n;
    n = frame_bits.size();
    build_stream(se);
    for (int k = 0; k < stream_q.size(); k++) begin
      if (stop_after >= 0 && k >= stop_after) return;
      gap();
      next_cycle();
      bit_tick = 1'b1;
      tx_start = (k == 0);
      if (stream_q[k].stuff) begin
        src_valid = 1'($urandom_range(0, 1));
        tx_q.push_back(mk_tx(1'b0, stream_q[k].b, 1'b1, 1'b0, 1'b1));
      end else if (stream_q[k].idx == und_at) begin
        tx_q.push_back(mk_tx(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        return;
      end else begin
        src_valid     = 1'b1;
        src_bit       = stream_q[k].b;
        src_stuff_end = (stream_q[k].idx == se);
        src_last      = (stream_q[k].idx == n - 1);
        tx_q.push_back(mk_tx(1'b1, stream_q[k].b, 1'b0, 1'b0, 1'b1));
      end
    end
    gap();
    next_cycle();
    bit_tick = 1'b1;
    tx_q.push_back(mk_tx(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  // Receives the stuffed form of frame_bits; corrupt flips one stuff bit, restart_at abandons mid-frame.
  task automatic rx_frame(input int se, input logic corrupt, input int restart_at);
    int   nst, ck, sc;
    logic errd;
    build_stream(se);
    nst = 0;
    foreach (stream_q[i]) if (stream_q[i].stuff) nst++;
    ck = (corrupt && nst > 0) ? int'($urandom_range(0, nst - 1)) : -1;
    sc = 0; errd = 1'b0;
    rx_se_done = 1'b0;
    next_cycle();
    rx_start = 1'b1;
    for (int k = 0; k < stream_q.size(); k++) begin
      if (k == restart_at) return;
      gap();
      next_cycle();
      bit_tick = 1'b1;
      tx_q.push_back(mk_tx(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      if (stream_q[k].stuff) begin
        if (sc == ck) begin
          rx_bit = ~stream_q[k].b;
          rx_q.push_back(mk_rx(1'b1, 1'b0));
          errd = 1'b1;
        end else begin
          rx_bit = stream_q[k].b;
        end
        sc++;
        if (errd) break;
      end else begin
        rx_bit = stream_q[k].b;
        rx_q.push_back(mk_rx(1'b0, stream_q[k].b));
        if (stream_q[k].idx == se) rx_se_done = 1'b1;
      end
    end
    if (errd) begin
      repeat (2) begin
        next_cycle();
        bit_tick = 1'b1;
        rx_bit = 1'($urandom_range(0, 1));
        tx_q.push_back(mk_tx(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      end
    end
    next_cycle();
    rx_stop = 1'b1;
    rx_se_done = 1'b0;
  endtask

  // Raw bus bits from rx_bits with no stuff_end; caller pushes the expectations.
  task automatic rx_raw(input logic with_stop);
    next_cycle();
    rx_start = 1'b1;
    rx_stop  = with_stop;
    for (int k = 0; k < rx_bits.size(); k++) begin
      gap();
      next_cycle();
      bit_tick = 1'b1;
      rx_bit = rx_bits[k];
      tx_q.push_back(mk_tx(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    next_cycle();
    rx_stop = 1'b1;
  endtask

  task automatic check_reset_values();
    check("rst_tx_bit", 8'(tx_bit), 8'd1);
    check("rst_tx_stuff", 8'(tx_stuff), 8'd0);
    check("rst_tx_busy", 8'(tx_busy), 8'd0);
    check("rst_tx_underrun", 8'(tx_underrun), 8'd0);
    check("rst_src_ready", 8'(src_ready), 8'd0);
    check("rst_rx_data", 8'(rx_data), 8'd1);
    check("rst_rx_data_valid", 8'(rx_data_valid), 8'd0);
    check("rst_stuff_error", 8'(stuff_error), 8'd0);
  endtask

  // Monitor: src_ready is compared in the tick cycle, bus outputs one cycle later.
  initial begin
    tx_exp_t te;
    rx_exp_t re;
    forever begin
      @(negedge clock);
      if (tx_have) begin
        check("tx_out{bit,stuff,underrun,busy}", 8'({tx_bit, tx_stuff, tx_underrun, tx_busy}),
              8'({te.b, te.stuff, te.und, te.busy}));
        tx_have = 1'b0;
      end
      if (bit_tick && !reset) begin
        if (tx_q.size() == 0) begin
          check("tx_tick_without_expectation", 8'd1, 8'd0);
        end else begin
          te = tx_q.pop_front();
          check("src_ready", 8'(src_ready), 8'(te.ready));
          tx_have = 1'b1;
        end
      end
      if (!reset && (rx_data_valid === 1'b1 || stuff_error === 1'b1)) begin
        if (rx_q.size() == 0) begin
          check("rx_unexpected_event{err,data}", 8'({stuff_error, rx_data}), 8'hff);
        end else begin
          re = rx_q.pop_front();
          check("rx_event{err,data}", 8'({stuff_error, rx_data_valid ? rx_data : 1'b0}),
                8'({re.err, re.b}));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, se, und;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_values();

    // Five zeros then a 1 ending the stuffed region: stuff bit 1 precedes it.
    frame_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tx_frame(5, -1, -1);
    // Five ones ending the region: trailing stuff bit 0, then six unstuffed ones.
    frame_bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tx_frame(4, -1, -1);
    // Underrun inside the stuffed region.
    frame_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tx_frame(7, 3, -1);

    rx_bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    repeat (6) rx_q.push_back(mk_rx(1'b0, 1'b1));
    rx_raw(1'b0);
    // rx_start together with rx_stop: start wins, run begins at 0.
    rx_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (5) rx_q.push_back(mk_rx(1'b0, 1'b0));
    rx_q.push_back(mk_rx(1'b1, 1'b0));
    rx_raw(1'b1);

    // Reset while a stuff bit is on the bus, with other inputs active.
    frame_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tx_frame(5, -1, 6);
    next_cycle();
    next_cycle();
    reset = 1'b1; bit_tick = 1'b1; tx_start = 1'b1; src_valid = 1'b1; rx_start = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check_reset_values();

    for (int it = 0; it < 60; it++) begin
      n  = int'($urandom_range(8, 40));
      se = int'($urandom_range(n / 2, n - 2));
      rand_frame(n);
      if ($urandom_range(0, 1) == 0) begin
        und = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
        tx_frame(se, und, -1);
      end else begin
        if ($urandom_range(0, 4) == 0) begin
          rx_frame(se, 1'b0, int'($urandom_range(2, 20)));
          n  = int'($urandom_range(8, 40));
          se = int'($urandom_range(n / 2, n - 2));
          rand_frame(n);
        end
        rx_frame(se, 1'($urandom_range(0, 3) == 0), -1);
      end
    end

    repeat (4) next_cycle();
    @(negedge clock);
    check("tx_expectations_left", 8'(tx_q.size() + (tx_have ? 1 : 0)), 8'd0);
    check("rx_expectations_left", 8'(rx_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
